// File: rtl/kernel_onchip_ram_pipelined.sv
// -----------------------------------------------------------------------------
// kernel_onchip_ram_pipelined
//
// Single-port on-chip RAM behind an Avalon-MM slave. It is intended as
// program/data or scratch memory on a Nios data master.
//
// Features:
//   - configurable width, depth and read latency (1 or 2 enabled cycles)
//   - byte-lane writes
//   - pipelined reads with readdatavalid
//   - waitrequest back-pressure
//   - hardware zero-fill engine, run after reset and on request
//   - out-of-range protection with a sticky error flag
//
// Parameters:
//   DATA_WIDTH     : data bus width in bits; must be a multiple of 8.
//   ADDR_WIDTH     : word address width.
//   DEPTH          : number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
//   READ_LATENCY   : enabled cycles from read accept to readdatavalid.
//                    Only 1 and 2 are legal; any value other than 1 builds
//                    the 2-cycle pipeline.
//   CLEAR_ON_RESET : 1 = zero-fill the whole array after reset release.
//
// Ports:
//   clk_i           : single clock; all logic is rising-edge.
//   reset_n_i       : asynchronous active-low reset.
//   address_i       : word address.
//   byteenable_i    : write byte lanes.
//   chipselect_i    : slave select.
//   read_i          : read request.
//   write_i         : write request.
//   writedata_i     : write data.
//   clken_i         : clock enable; low freezes the whole block.
//   freeze_i        : high discards writes; reads still proceed.
//   clear_req_i     : single-cycle pulse that starts a zero-fill.
//   readdata_o      : read data; holds its last value between results.
//   readdatavalid_o : readdata_o carries a fresh result this cycle.
//   waitrequest_o   : request not accepted this cycle.
//   clear_busy_o    : zero-fill in progress.
//   range_err_o     : sticky flag; an access to address >= DEPTH occurred.
// -----------------------------------------------------------------------------
module kernel_onchip_ram_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int DEPTH          = 2560,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [ADDR_WIDTH-1:0]   address_i,
    input  logic [DATA_WIDTH/8-1:0] byteenable_i,
    input  logic                    chipselect_i,
    input  logic                    read_i,
    input  logic                    write_i,
    input  logic [DATA_WIDTH-1:0]   writedata_i,
    input  logic                    clken_i,
    input  logic                    freeze_i,
    input  logic                    clear_req_i,
    output logic [DATA_WIDTH-1:0]   readdata_o,
    output logic                    readdatavalid_o,
    output logic                    waitrequest_o,
    output logic                    clear_busy_o,
    output logic                    range_err_o
);

    localparam int NB = DATA_WIDTH / 8;

    // One extra bit so that DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Signal declarations
    // -------------------------------------------------------------------------

    // Zero-fill FSM.
    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q;
    logic [ADDR_WIDTH-1:0]   clr_addr_d;

    // Bus handshake decode.
    logic                    clearing;
    logic                    wait_req;
    logic                    access_acc;
    logic                    rd_acc;
    logic                    wr_acc;
    logic                    in_range;

    // Shared RAM write port (bus writes and the clear engine).
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [NB-1:0]           ram_wbe;
    logic [NB-1:0]           lane_we;

    // Storage and status.
    logic [DATA_WIDTH-1:0]   ram_mem [DEPTH];
    logic                    range_err_q;

    // Read pipeline outputs, driven by whichever latency variant is built.
    logic [DATA_WIDTH-1:0]   readdata_int;
    logic                    rvalid_int;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    assign in_range   = ({1'b0, address_i} < DEPTH_L);
    assign clearing   = (state_q == ST_CLEAR);
    assign wait_req   = clearing | ~clken_i;
    assign access_acc = chipselect_i & (read_i | write_i) & ~wait_req;
    assign wr_acc     = access_acc & write_i;

    // A simultaneous read and write is treated as a write only.
    assign rd_acc     = access_acc & read_i & ~write_i;

    // -------------------------------------------------------------------------
    // Zero-fill FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_READY: begin
                // The pulse is taken even while clken is low so it is never lost.
                if (clear_req_i) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                // clear_req_i is ignored here; the running fill just continues.
                if (clken_i) begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d    = ST_READY;
                        clr_addr_d = '0;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_READY;
                clr_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // -------------------------------------------------------------------------
    // RAM write port
    // -------------------------------------------------------------------------
    // The clear engine owns the port while clearing; the bus is stalled then
    // anyway. Otherwise only accepted, unfrozen, in-range writes reach the RAM.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = address_i;
        ram_wdata = writedata_i;
        ram_wbe   = byteenable_i;
        if (clearing) begin
            ram_we    = clken_i;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
            ram_wbe   = '1;
        end else if (wr_acc && !freeze_i && in_range) begin
            ram_we = 1'b1;
        end
    end

    // Per-lane write enables.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane_we
        assign lane_we[gi] = ram_we & ram_wbe[gi];
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (lane_we[b]) begin
                ram_mem[ram_waddr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sticky range error
    // -------------------------------------------------------------------------
    // Set on any accepted access (read, write or both) to address >= DEPTH.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            range_err_q <= 1'b0;
        end else if (access_acc && !in_range) begin
            range_err_q <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline
    // -------------------------------------------------------------------------
    // A write and a read of the same word on consecutive cycles need no bypass:
    // the write lands on the edge before the read samples the array.
    if (READ_LATENCY == 1) begin : g_lat1
        logic [DATA_WIDTH-1:0] ram_rd_q;
        logic                  zero_q;
        logic                  valid_q;

        // RAM output register; only loads on an accepted read, so it holds.
        always_ff @(posedge clk_i) begin
            if (rd_acc) begin
                ram_rd_q <= ram_mem[address_i];
            end
        end

        // zero_q masks the RAM output after reset and for out-of-range reads,
        // which keeps ram_rd_q free of reset logic.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                zero_q  <= 1'b1;
                valid_q <= 1'b0;
            end else if (clken_i) begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    zero_q <= ~in_range;
                end
            end
        end

        assign readdata_int = zero_q ? '0 : ram_rd_q;
        assign rvalid_int   = valid_q;
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] ram_rd_q;
        logic                  s1_valid_q;
        logic                  s1_oor_q;
        logic [DATA_WIDTH-1:0] out_data_q;
        logic                  out_valid_q;

        // Stage 1: RAM output register.
        always_ff @(posedge clk_i) begin
            if (rd_acc) begin
                ram_rd_q <= ram_mem[address_i];
            end
        end

        // Stage 2: output register. It only loads when a result arrives, so
        // readdata holds between results and while clken is low.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                s1_valid_q  <= 1'b0;
                s1_oor_q    <= 1'b0;
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else if (clken_i) begin
                s1_valid_q  <= rd_acc;
                if (rd_acc) begin
                    s1_oor_q <= ~in_range;
                end
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= s1_oor_q ? '0 : ram_rd_q;
                end
            end
        end

        assign readdata_int = out_data_q;
        assign rvalid_int   = out_valid_q;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // A result waiting in the pipeline while clken is low stays registered;
    // it is only hidden, and appears once clken returns.
    assign readdata_o      = readdata_int;
    assign readdatavalid_o = rvalid_int & clken_i;
    assign waitrequest_o   = wait_req;
    assign clear_busy_o    = clearing;
    assign range_err_o     = range_err_q;

endmodule

// File: doc/kernel_onchip_ram_pipelined.md
Name: kernel_onchip_ram_pipelined

Overview:
Parametrised single-port on-chip RAM with an Avalon-MM slave interface. It replaces the fixed 32-bit x 2560-word, zero-latency memory. Data width, depth and read latency are configurable. It adds pipelined reads with readdatavalid, waitrequest back-pressure, a hardware zero-fill engine and out-of-range protection. It sits on the Nios data master as program/data or scratch RAM.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8.
ADDR_WIDTH, 12, word address width.
DEPTH, 2560, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values are 1 and 2.
CLEAR_ON_RESET, 1, when 1 the RAM is zero-filled after reset release.

Ports:
clk  in  1  single clock; all logic is rising-edge.
reset_n  in  1  asynchronous active-low reset.
address  in  ADDR_WIDTH  word address.
byteenable  in  DATA_WIDTH/8  byte lanes for writes.
chipselect  in  1  slave select.
read  in  1  read request.
write  in  1  write request.
writedata  in  DATA_WIDTH  write data.
clken  in  1  clock enable; low stalls the block.
freeze  in  1  high blocks writes; reads still proceed.
clear_req  in  1  single-cycle pulse that starts a zero-fill.
readdata  out  DATA_WIDTH  read data.
readdatavalid  out  1  readdata is valid this cycle.
waitrequest  out  1  request not accepted this cycle.
clear_busy  out  1  zero-fill in progress.
range_err  out  1  sticky flag: an access to address >= DEPTH occurred.

Behaviour:
- Clocking and reset: one clock domain, clk. reset_n is asynchronous, active-low.
- Reset values:
  - readdata=0, readdatavalid=0, range_err=0.
  - The pipeline is emptied.
  - FSM goes to CLEAR with clear_busy=1 and waitrequest=1 if CLEAR_ON_RESET=1; otherwise to READY with waitrequest=0.
  - RAM contents are not reset.
- FSM states:
  - READY: clear_req=1 -> CLEAR.
  - CLEAR: a counter clr_addr starts at 0 and writes all-zero words, one per cycle when clken=1. After clr_addr=DEPTH-1 is written -> READY on the next cycle. Total DEPTH enabled cycles.
  - clear_req is ignored while already in CLEAR.
  - reset_n asserted mid-clear restarts the sequence from the reset state.
  - freeze does not block the clear engine.
- waitrequest = (state==CLEAR) | ~clken.
- Accept condition: chipselect & (read|write) & ~waitrequest.
- Writes:
  - A write is performed if write=1 and freeze=0. Only bytes with byteenable=1 are updated.
  - A write while freeze=1 is accepted (no stall) and discarded.
- Reads:
  - readdatavalid pulses exactly READ_LATENCY enabled cycles after accept, one cycle per accepted read.
  - Back-to-back reads give one result per cycle, in order.
- read and write high together: the write is performed, the read is dropped, and no readdatavalid is produced.
- Read-after-write to the same address on consecutive cycles returns the new data; there is no stale bypass gap.
- clken=0:
  - The read pipeline, clear counter and RAM hold.
  - readdatavalid is forced to 0 while clken=0; a pending result emerges after clken returns high.
  - readdata holds its last value.
- Out of range (address >= DEPTH):
  - A write is dropped.
  - A read returns all zeros with a normal readdatavalid.
  - range_err is set in both cases; it clears only on reset.
- readdata keeps its last valid value when readdatavalid=0.

Test Plan:
1. Reset release with CLEAR_ON_RESET=1, DEPTH=2560 -> waitrequest=1 and clear_busy=1 for 2560 cycles, then 0. Reads of addresses 0, 1279 and 2559 return 0.
2. Write 0xDEADBEEF to addr 5 with byteenable=4'b1111, then write 0x000000AA with byteenable=4'b0001, then read addr 5 -> readdata=0xDEADBEAA with readdatavalid exactly READ_LATENCY cycles after accept. Run with READ_LATENCY=1 and 2.
3. Burst of 8 back-to-back reads of addrs 0..7, preloaded with the value of the address -> 8 consecutive readdatavalid pulses returning data 0..7 in order. Drop clken low for 3 cycles mid-burst -> waitrequest=1, no valid pulses during the stall, order preserved afterwards.
4. With freeze=1, write 0x12345678 to addr 10 -> no stall; a later read of addr 10 returns the previous value. Write to addr 2600 -> range_err=1; a read of addr 2600 returns 0.
5. Write nonzero data, pulse clear_req, pulse reset_n low after 100 clear cycles -> clear restarts from 0 and completes in 2560 cycles. All locations read 0; range_err=0.
6. Assert read=1 and write=1 together on addr 20 with data 0x55 -> no readdatavalid pulse; a later read of addr 20 returns 0x55.
